// File: rtl/orb_frame_reader.sv
// orb_frame_reader: reads one frame of packed 12-bit words from the frame RAM,
// unpacks the payload byte and channel, and offers each byte on a valid/ready port.
module orb_frame_reader #(
  parameter int ADDR_W      = 11,
  parameter int FRAME_WORDS = 2048,
  parameter int WORD_W      = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iStart,
  input  logic              SW,
  output logic [ADDR_W-1:0] RdAddr,
  output logic              RdEn,
  input  logic [WORD_W-1:0] iRamData,
  output logic [7:0]        oData,
  output logic              oChan,
  output logic              oValid,
  input  logic              iReady,
  output logic              busy,
  output logic              frameDone,
  output logic              fmtErr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;

  logic start_s1, start_s2, start_d, start_pulse;
  logic sw_s1, sw_s2, sw_old;
  logic sw_change;
  logic word_bad;

  // A word is malformed if the spare top bit or any of the low pad bits is set.
  assign word_bad  = iRamData[11] | (|iRamData[2:0]);
  assign sw_change = sw_s2 ^ sw_old;

  // Two-stage synchronizers for the async strobes; the start edge is registered
  // so the FSM sees a clean one-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_s1    <= 1'b0;
      start_s2    <= 1'b0;
      start_d     <= 1'b0;
      start_pulse <= 1'b0;
      sw_s1       <= 1'b0;
      sw_s2       <= 1'b0;
      sw_old      <= 1'b0;
    end else begin
      start_s1    <= iStart;
      start_s2    <= start_s1;
      start_d     <= start_s2;
      start_pulse <= start_s2 & ~start_d;
      sw_s1       <= SW;
      sw_s2       <= sw_s1;
      sw_old      <= sw_s2;
    end
  end

  // Frame sequencer: one RAM read, one capture cycle, then hold the byte until
  // accepted. An SW change aborts everything (including a coincident start).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      RdAddr    <= '0;
      RdEn      <= 1'b0;
      oData     <= '0;
      oChan     <= 1'b0;
      oValid    <= 1'b0;
      busy      <= 1'b0;
      frameDone <= 1'b0;
      fmtErr    <= 1'b0;
    end else if (sw_change) begin
      state     <= S_IDLE;
      addr      <= '0;
      RdEn      <= 1'b0;
      oValid    <= 1'b0;
      busy      <= 1'b0;
      frameDone <= 1'b0;
    end else begin
      RdEn      <= 1'b0;
      frameDone <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_pulse) begin
            addr   <= '0;
            RdAddr <= '0;
            RdEn   <= 1'b1;
            fmtErr <= 1'b0;
            busy   <= 1'b1;
            state  <= S_READ;
          end
        end
        S_READ: begin
          state <= S_LATCH;
        end
        S_LATCH: begin
          oData  <= iRamData[10:3];
          oChan  <= addr[0];
          oValid <= 1'b1;
          if (word_bad) fmtErr <= 1'b1;
          state  <= S_HOLD;
        end
        S_HOLD: begin
          if (iReady) begin
            oValid <= 1'b0;
            if (addr == LAST_ADDR) begin
              frameDone <= 1'b1;
              busy      <= 1'b0;
              state     <= S_DONE;
            end else begin
              // RdEn is registered, so the next read is issued on this same edge.
              addr   <= addr + 1'b1;
              RdAddr <= addr + 1'b1;
              RdEn   <= 1'b1;
              state  <= S_READ;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_orb_frame_reader.sv
// tb_orb_frame_reader: drives an 8-word and a default 2048-word reader against
// behavioural RAMs and checks the byte stream against a frame-level model.
module tb_orb_frame_reader;

  localparam int FW8 = 8;
  localparam int FWF = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sw, start8, startf, ready8, readyf;
  logic [10:0] rdaddr8, rdaddrf;
  logic        rden8, rdenf;
  logic [11:0] ramq8, ramqf;
  logic [7:0]  odata8, odataf;
  logic        ochan8, ochanf, ovalid8, ovalidf;
  logic        busy8, busyf, done8, donef, fmterr8, fmterrf;

  orb_frame_reader #(.ADDR_W(11), .FRAME_WORDS(FW8), .WORD_W(12)) dut8 (
    .clk(clk), .rst(rst), .iStart(start8), .SW(sw),
    .RdAddr(rdaddr8), .RdEn(rden8), .iRamData(ramq8),
    .oData(odata8), .oChan(ochan8), .oValid(ovalid8), .iReady(ready8),
    .busy(busy8), .frameDone(done8), .fmtErr(fmterr8));

  orb_frame_reader #(.ADDR_W(11), .FRAME_WORDS(FWF), .WORD_W(12)) dutf (
    .clk(clk), .rst(rst), .iStart(startf), .SW(sw),
    .RdAddr(rdaddrf), .RdEn(rdenf), .iRamData(ramqf),
    .oData(odataf), .oChan(ochanf), .oValid(ovalidf), .iReady(readyf),
    .busy(busyf), .frameDone(donef), .fmtErr(fmterrf));

  logic [11:0] mem8 [0:FW8-1];
  logic [11:0] memf [0:FWF-1];

  // Synchronous-read RAMs: data appears the cycle after RdEn.
  always @(posedge clk) begin
    if (rden8) ramq8 <= mem8[rdaddr8[2:0]];
    if (rdenf) ramqf <= memf[rdaddrf];
  end

  int nchecks = 0;
  int nfails  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nfails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // iReady driver: mode 0 low, 1 high, 2 random; the full-frame reader is always random.
  int mode8 = 1;
  initial begin
    ready8 = 1'b1;
    readyf = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (mode8)
        0:       ready8 = 1'b0;
        1:       ready8 = 1'b1;
        default: ready8 = ($urandom_range(0, 3) != 0);
      endcase
      readyf = ($urandom_range(0, 3) != 0);
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       chan;
    logic       err;
  } beat_t;

  beat_t exp8[$];
  beat_t expf[$];

  int   idx8 = 0, done_cnt8 = 0, rden_cnt8 = 0;
  int   acc_cyc8[$];
  logic busy_p8 = 1'b0, stall_p8 = 1'b0, chk_stall = 1'b1;
  logic [9:0] stall_v8 = '0;

  // Monitor for the 8-word reader; the expected frame is rebuilt from RAM on each start.
  initial begin
    beat_t b;
    logic  e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_p8  = 1'b0;
        stall_p8 = 1'b0;
      end else begin
        if (busy8 && !busy_p8) begin
          exp8.delete();
          e = 1'b0;
          for (int n = 0; n < FW8; n++) begin
            e = e | mem8[n][11] | (mem8[n][2:0] != 3'b000);
            exp8.push_back('{data: mem8[n][10:3], chan: n[0], err: e});
          end
          idx8 = 0;
        end
        if (rden8) begin
          rden_cnt8++;
          check("rdaddr8", 32'(rdaddr8), idx8);
          check("rden_with_valid8", 32'(ovalid8), 32'(0));
        end
        if (stall_p8 && chk_stall)
          check("stall_hold8", 32'({ovalid8, ochan8, odata8}), 32'(stall_v8));
        if (ovalid8 && ready8) begin
          if (exp8.size() == 0) begin
            check("extra_word8", idx8, FW8 - 1);
          end else begin
            b = exp8.pop_front();
            check("data8", 32'(odata8), 32'(b.data));
            check("chan8", 32'(ochan8), 32'(b.chan));
            check("fmterr8", 32'(fmterr8), 32'(b.err));
          end
          idx8++;
          acc_cyc8.push_back(cyc);
        end
        stall_p8 = ovalid8 && !ready8;
        stall_v8 = {1'b1, ochan8, odata8};
        if (done8) begin
          done_cnt8++;
          check("done_busy8", 32'(busy8), 32'(0));
          check("done_words8", idx8, FW8);
        end
        busy_p8 = busy8;
      end
    end
  end

  int          idxf = 0, done_cntf = 0;
  logic        busy_pf = 1'b0;
  logic [10:0] last_addrf = '0;

  // Monitor for the default-size reader.
  initial begin
    beat_t b;
    logic  e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_pf = 1'b0;
      end else begin
        if (busyf && !busy_pf) begin
          expf.delete();
          e = 1'b0;
          for (int n = 0; n < FWF; n++) begin
            e = e | memf[n][11] | (memf[n][2:0] != 3'b000);
            expf.push_back('{data: memf[n][10:3], chan: n[0], err: e});
          end
          idxf = 0;
        end
        if (rdenf) begin
          check("rdaddrf", 32'(rdaddrf), idxf);
          last_addrf = rdaddrf;
        end
        if (ovalidf && readyf) begin
          if (expf.size() == 0) begin
            check("extra_wordf", idxf, FWF - 1);
          end else begin
            b = expf.pop_front();
            check("dataf", 32'(odataf), 32'(b.data));
            check("chanf", 32'(ochanf), 32'(b.chan));
            check("fmterrf", 32'(fmterrf), 32'(b.err));
          end
          idxf++;
        end
        if (donef) begin
          done_cntf++;
          check("done_wordsf", idxf, FWF);
        end
        busy_pf = busyf;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start8;
    start8 = 1'b1;
    cycles(4);
    start8 = 1'b0;
  endtask

  task automatic wait_idx8(input int k, input int budget);
    int n = 0;
    while (!(ovalid8 && idx8 == k) && n < budget) begin
      cycles(1);
      n++;
    end
    check("wait_word8", 32'(ovalid8 && idx8 == k), 32'(1));
  endtask

  task automatic wait_done8(input int target, input int budget);
    int n = 0;
    while (done_cnt8 < target && n < budget) begin
      cycles(1);
      n++;
    end
    check("frame_done8", 32'(done_cnt8 >= target), 32'(1));
    cycles(4);
    check("done_count8", done_cnt8, target);
  endtask

  task automatic run_frame8(input int budget);
    int d0;
    d0 = done_cnt8;
    pulse_start8();
    wait_done8(d0 + 1, budget);
  endtask

  task automatic fill_ramp8;
    for (int n = 0; n < FW8; n++) mem8[n] = {1'b0, 8'(8'hA0 + n), 3'b000};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, r0, n, k;
    rst    = 1'b0;
    sw     = 1'b0;
    start8 = 1'b0;
    startf = 1'b0;
    fill_ramp8();
    for (int i = 0; i < FWF; i++) memf[i] = '0;

    cycles(3);
    check("reset_outs8", 32'({rdaddr8, rden8, odata8, ochan8, ovalid8, busy8, done8, fmterr8}), 32'(0));
    check("reset_outsf", 32'({rdaddrf, rdenf, odataf, ochanf, ovalidf, busyf, donef, fmterrf}), 32'(0));
    rst = 1'b1;
    cycles(5);

    // Ramp frame, iReady high: latency from raw start, spacing, single done.
    mode8 = 1;
    d0 = done_cnt8;
    acc_cyc8.delete();
    start8 = 1'b1;
    n = 0;
    while (!ovalid8 && n < 20) begin
      cycles(1);
      n++;
    end
    check("start_latency8", n, 6);
    start8 = 1'b0;
    wait_done8(d0 + 1, 200);
    check("beats8", acc_cyc8.size(), FW8);
    for (int i = 1; i < acc_cyc8.size(); i++)
      check("beat_spacing8", acc_cyc8[i] - acc_cyc8[i-1], 3);
    check("idle_busy8", 32'(busy8), 32'(0));

    // Backpressure on word 3 for 10 cycles.
    d0 = done_cnt8;
    pulse_start8();
    wait_idx8(3, 100);
    mode8 = 0;
    r0 = rden_cnt8;
    cycles(10);
    check("stall_data8", 32'(odata8), 32'(8'hA3));
    check("stall_valid8", 32'(ovalid8), 32'(1));
    check("stall_rden8", rden_cnt8 - r0, 0);
    mode8 = 1;
    wait_done8(d0 + 1, 200);

    // Second start edge mid-frame is ignored.
    d0 = done_cnt8;
    pulse_start8();
    wait_idx8(4, 100);
    pulse_start8();
    wait_done8(d0 + 1, 200);
    cycles(20);
    check("no_requeue_busy8", 32'(busy8), 32'(0));
    check("no_requeue_done8", done_cnt8, d0 + 1);

    // SW toggle while holding word 5 aborts; next frame restarts from address 0.
    d0 = done_cnt8;
    pulse_start8();
    wait_idx8(5, 100);
    mode8 = 0;
    chk_stall = 1'b0;
    cycles(1);
    sw = ~sw;
    n = 0;
    while (ovalid8 && n < 10) begin
      cycles(1);
      n++;
    end
    check("abort_latency8", 32'(n <= 3), 32'(1));
    cycles(5);
    check("abort_busy8", 32'(busy8), 32'(0));
    check("abort_no_done8", done_cnt8, d0);
    mode8 = 1;
    chk_stall = 1'b1;
    run_frame8(200);

    // Format error on word 2 is sticky, then cleared by a clean frame.
    mem8[2] = 12'h801;
    run_frame8(200);
    check("fmterr_sticky8", 32'(fmterr8), 32'(1));
    fill_ramp8();
    run_frame8(200);
    check("fmterr_cleared8", 32'(fmterr8), 32'(0));

    // Random payloads, random iReady, occasional malformed words.
    mode8 = 2;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < FW8; i++) begin
        mem8[i] = {1'b0, 8'($urandom_range(0, 255)), 3'b000};
        if (f % 2 == 1 && $urandom_range(0, 5) == 0) begin
          k = $urandom_range(0, 3);
          if (k == 3) mem8[i][11] = 1'b1;
          else        mem8[i][k]  = 1'b1;
        end
      end
      run_frame8(600);
    end
    mode8 = 1;

    // Reset mid-frame clears outputs immediately and leaves the reader idle.
    fill_ramp8();
    d0 = done_cnt8;
    pulse_start8();
    wait_idx8(3, 100);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rst_async8", 32'({rdaddr8, rden8, odata8, ochan8, ovalid8, busy8, done8, fmterr8}), 32'(0));
    @(posedge clk);
    #3;
    rst = 1'b1;
    cycles(15);
    check("post_rst_busy8", 32'(busy8), 32'(0));
    check("post_rst_valid8", 32'(ovalid8), 32'(0));
    check("post_rst_done8", done_cnt8, d0);
    run_frame8(200);

    // Full default-size frame with random data and random iReady.
    for (int i = 0; i < FWF; i++) memf[i] = {1'b0, 8'($urandom_range(0, 255)), 3'b000};
    d0 = done_cntf;
    startf = 1'b1;
    cycles(4);
    startf = 1'b0;
    n = 0;
    while (done_cntf == d0 && n < 40000) begin
      cycles(1);
      n++;
    end
    cycles(4);
    check("full_done", done_cntf, d0 + 1);
    check("full_last_addr", 32'(last_addrf), 32'(11'h7FF));
    check("full_words", idxf, FWF);
    check("full_busy", 32'(busyf), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfails);
    $finish;
  end

endmodule
